axis_pbs_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges NUM_INPUTS AXI4-Stream input queues onto the single AXIS stream feeding the AXIS-to-PBS bridge. It sits between the per-port receive queues and the bridge and owns the bridge's input for one whole packet at a time, so the module header the bridge emits always describes one contiguous packet. Grant rotates fairly across requesting inputs, and a software-driven enable mask can exclude inputs.

---
 rtl/axis_pbs_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_axis_pbs_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pbs_rr_arbiter.sv
// axis_pbs_rr_arbiter
// Packet-granular round-robin arbiter. It merges NUM_INPUTS AXI4-Stream queues
// onto the single AXIS stream that feeds the AXIS-to-PBS bridge. An input keeps
// the output from its first beat until its tlast beat, so the bridge always sees
// contiguous packets. in_enable can exclude inputs; it is only looked at while
// idle, so an input that is dropped mid-packet still finishes its packet.
//
// Optional build macro AXIS_PBS_ARB_SRC_STAMP_EN: when it is defined, the
// 8-bit source-port field of m_axis_tuser at C_AXIS_SRC_PORT_POS is overwritten
// with one-hot(grant_idx), and the unused upper bits of that field read as zero.
module axis_pbs_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH   = 64,
    parameter int C_AXIS_USER_WIDTH   = 128,
    parameter int C_AXIS_SRC_PORT_POS = 16,
    parameter int NUM_INPUTS          = 4,
    parameter int NUM_INPUTS_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_INPUTS*C_AXIS_USER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                   s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]                   s_axis_tlast,
    output logic [NUM_INPUTS-1:0]                   s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
    output logic [C_AXIS_USER_WIDTH-1:0]            m_axis_tuser,
    output logic                                    m_axis_tvalid,
    output logic                                    m_axis_tlast,
    input  logic                                    m_axis_tready,
    input  logic [NUM_INPUTS-1:0]                   in_enable,
    output logic [NUM_INPUTS_WIDTH-1:0]             grant_idx,
    output logic                                    busy
);

    localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                      state_reg;
    logic [NUM_INPUTS_WIDTH-1:0] last_grant_reg;
    logic [NUM_INPUTS_WIDTH-1:0] grant_next;
    logic [NUM_INPUTS-1:0]       req;
    logic                        req_found;

    logic [C_AXIS_DATA_WIDTH-1:0] data_arr [NUM_INPUTS];
    logic [STRB_WIDTH-1:0]        strb_arr [NUM_INPUTS];
    logic [C_AXIS_USER_WIDTH-1:0] user_arr [NUM_INPUTS];
    logic [C_AXIS_USER_WIDTH-1:0] user_sel;

    // The one-hot source field is 8 bits wide, which limits the input count
    // to 8, and the field has to fit inside tuser.
    generate
        if (NUM_INPUTS < 2 || NUM_INPUTS > 8 ||
            C_AXIS_SRC_PORT_POS + 8 > C_AXIS_USER_WIDTH) begin : g_bad_cfg
            $error("axis_pbs_rr_arbiter: illegal parameter combination");
        end
    endgenerate

    // Unpack the flat input buses into one array entry per input.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slice
            assign data_arr[gi] = s_axis_tdata[gi*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            assign strb_arr[gi] = s_axis_tstrb[gi*STRB_WIDTH +: STRB_WIDTH];
            assign user_arr[gi] = s_axis_tuser[gi*C_AXIS_USER_WIDTH +: C_AXIS_USER_WIDTH];
        end
    endgenerate

    // Round-robin pick: find the first enabled requester after last_grant, with wrap-around.
    always_comb begin
        req        = s_axis_tvalid & in_enable;
        grant_next = '0;
        req_found  = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            int idx;
            idx = (int'(last_grant_reg) + k) % NUM_INPUTS;
            if (!req_found && req[idx]) begin
                req_found  = 1'b1;
                grant_next = NUM_INPUTS_WIDTH'(idx);
            end
        end
    end

    // Two-state packet FSM; grant_idx and busy are held in registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            grant_idx      <= '0;
            last_grant_reg <= NUM_INPUTS_WIDTH'(NUM_INPUTS - 1);
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_found) begin
                        grant_idx <= grant_next;
                        state_reg <= XFER;
                        busy      <= 1'b1;
                    end
                end
                XFER: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        last_grant_reg <= grant_idx;
                        state_reg      <= IDLE;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Output mux from the granted input. Handshake signals are gated to XFER only.
    always_comb begin
        m_axis_tdata  = data_arr[grant_idx];
        m_axis_tstrb  = strb_arr[grant_idx];
        m_axis_tlast  = s_axis_tlast[grant_idx];
        user_sel      = user_arr[grant_idx];
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state_reg == XFER) begin
            m_axis_tvalid            = s_axis_tvalid[grant_idx];
            s_axis_tready[grant_idx] = m_axis_tready;
        end
    end

`ifdef AXIS_PBS_ARB_SRC_STAMP_EN
    // Overwrite the source-port field with one-hot(grant_idx); the remaining tuser bits pass through.
    always_comb begin
        m_axis_tuser = user_sel;
        m_axis_tuser[C_AXIS_SRC_PORT_POS +: 8] = 8'(8'd1 << grant_idx);
    end
`else
    // Pass tuser through unmodified.
    always_comb begin
        m_axis_tuser = user_sel;
    end
`endif

endmodule

// File: tb/tb_axis_pbs_rr_arbiter.sv
// Directed testbench for axis_pbs_rr_arbiter (default parameters, 4 inputs).
// Each input is a small packet source. Every accepted output beat is compared
// against a per-input scoreboard, and the per-cycle owner of the output is
// compared against hand-computed tables (-1 marks a cycle with no beat).
module tb_axis_pbs_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int UW = 128;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N*DW-1:0] s_tdata;
    logic [N*SW-1:0] s_tstrb;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid, m_tlast, m_ready;
    logic [N-1:0]    in_enable;
    logic [1:0]      grant_idx;
    logic            busy;

    always #5 clk = ~clk;

    axis_pbs_rr_arbiter dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_ready),
        .in_enable(in_enable), .grant_idx(grant_idx), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Source state per input: queued packets, current beat, packet length, packet number.
    int pkts[N], beat[N], len[N], pno[N];
    // Scoreboard: the next beat expected from each input.
    int exp_pno[N], exp_beat[N];

    // Per-test tables: expected owner per cycle, m_axis_tready per cycle, and expected s_axis_tready.
    int expq[$];
    int rdyq[$];
    int trq[$];
    int en_change_at = -1;
    logic [N-1:0] en_change_val = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (pkts[i] > 0);
            s_tlast[i]  = (beat[i] == len[i] - 1);
            s_tdata[i*DW +: DW] = {8'(i), 8'(pno[i]), 8'(beat[i]), 40'h5A5A5A5A5A};
            s_tstrb[i*SW +: SW] = 8'(8'hF0 | i);
            s_tuser[i*UW +: UW] = {96'h0, 8'(8'hE0 + i), 8'h00, 8'hC3, 8'(8'h10 + i)};
        end
    endtask

    // One clock cycle: sample at the falling edge, then advance the sources just after the rising edge.
    task automatic cycle(input logic rdy, output int src, output logic [N-1:0] tr);
        logic [N-1:0] hs;
        logic [7:0]   stamp;
        int           id;
        m_ready = rdy;
        @(negedge clk);
        tr = s_tready;
        hs = s_tready & s_tvalid;
        src = -1;
        if (!busy) begin
            check("idle_valid", 64'(m_tvalid), 64'(0));
            check("idle_tready", 64'(s_tready), 64'(0));
        end else begin
            check("xfer_tready", 64'(s_tready), rdy ? 64'(4'b1 << grant_idx) : 64'(0));
        end
        if (m_tvalid && m_ready) begin
            id  = int'(m_tdata[63:56]);
            src = id;
            if (id >= N) begin
                check("src_id", 64'(id), 64'(0));
            end else begin
`ifdef AXIS_PBS_ARB_SRC_STAMP_EN
                stamp = 8'(1 << id);
`else
                stamp = 8'h00;
`endif
                check("grant_idx", 64'(grant_idx), 64'(id));
                check("beat_seq", 64'(m_tdata[55:40]), 64'({8'(exp_pno[id]), 8'(exp_beat[id])}));
                check("tlast", 64'(m_tlast), 64'(exp_beat[id] == len[id] - 1));
                check("tstrb", 64'(m_tstrb), 64'(8'hF0 | id));
                check("tuser", 64'(m_tuser[31:0]),
                      64'({8'(8'hE0 + id), stamp, 8'hC3, 8'(8'h10 + id)}));
                if (exp_beat[id] == len[id] - 1) begin
                    exp_beat[id] = 0;
                    exp_pno[id]++;
                end else begin
                    exp_beat[id]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pno[i]++;
                    pkts[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive_inputs();
    endtask

    // Run the cycles in expq and compare the per-cycle owner (and tready where trq is given).
    task automatic run_seq(input string tag);
        int src;
        logic [N-1:0] tr;
        logic rdy;
        for (int k = 0; k < expq.size(); k++) begin
            rdy = (k < rdyq.size()) ? logic'(rdyq[k]) : 1'b1;
            if (k == en_change_at) in_enable = en_change_val;
            cycle(rdy, src, tr);
            check($sformatf("%s_owner_c%0d", tag, k), 64'(src), 64'(expq[k]));
            if (k < trq.size())
                check($sformatf("%s_stready_c%0d", tag, k), 64'(tr), 64'(trq[k]));
        end
        rdyq.delete();
        trq.delete();
        en_change_at = -1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pkts[i] = 0; beat[i] = 0; len[i] = 1; pno[i] = 0;
            exp_pno[i] = 0; exp_beat[i] = 0;
        end
        resetn    = 1'b0;
        m_ready   = 1'b0;
        in_enable = 4'hF;
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_idx), 64'(0));
        check("rst_mvalid", 64'(m_tvalid), 64'(0));
        check("rst_stready", 64'(s_tready), 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // All four inputs send a 3-beat packet at the same time: order 0,1,2,3 with a one-cycle gap.
        for (int i = 0; i < N; i++) begin len[i] = 3; pkts[i] = 1; end
        drive_inputs();
        expq = '{-1, 0, 0, 0, -1, 1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3};
        run_seq("rr4");

        // One-beat packets on inputs 0 and 3 (last grant is 3): order 0, then 3.
        len[0] = 1; len[3] = 1; pkts[0] = 1; pkts[3] = 1;
        drive_inputs();
        expq = '{-1, 0, -1, 3};
        run_seq("onebeat");

        // Only input 2 requests, 5 packets of 2 beats: the grant stays on 2 and there is no extra gap.
        len[2] = 2; pkts[2] = 5;
        drive_inputs();
        expq = '{-1, 2, 2, -1, 2, 2, -1, 2, 2, -1, 2, 2, -1, 2, 2};
        run_seq("solo2");

        // Input 1 with m_axis_tready toggling 1,0,0,1: s_axis_tready[1] follows it exactly.
        len[1] = 4; pkts[1] = 1;
        drive_inputs();
        rdyq = '{1, 1, 0, 0, 1, 1, 1};
        trq  = '{0, 2, 0, 0, 2, 2, 2};
        expq = '{-1, 1, -1, -1, 1, 1, 1};
        run_seq("bp1");

        // in_enable=1011 (last grant 1): order 3, 0, 1 and input 2 is skipped.
        // Dropping in_enable[0] during input 0's packet does not cut that packet short.
        in_enable = 4'b1011;
        for (int i = 0; i < N; i++) begin len[i] = 2; pkts[i] = 1; end
        drive_inputs();
        en_change_at  = 5;
        en_change_val = 4'b1010;
        expq = '{-1, 3, 3, -1, 0, 0, -1, 1, 1, -1, -1, -1};
        run_seq("mask");
        check("mask_busy_idle", 64'(busy), 64'(0));
        in_enable = 4'hF;
        expq = '{-1, 2, 2};
        run_seq("unmask");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
